// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with mid-bit sampling, start-glitch rejection
//           and framing-error detection.                          Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
   parameter int CLK_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int          HALF_BIT    = CLK_PER_BIT / 2;
   localparam logic [15:0] C_BIT_LAST  = 16'(CLK_PER_BIT - 1);
   localparam logic [15:0] C_HALF_LAST = 16'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_s_q;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        busy_q;

   // Synchroniser flops preset high so leaving reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         clk_cnt_q <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= (state_q != S_IDLE);
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = 16'd0;
            if (!rx_s_q) state_d = S_START;
         end

         S_START: begin
            if (clk_cnt_q == C_HALF_LAST) begin
               clk_cnt_d = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

         S_DATA: begin
            if (clk_cnt_q == C_BIT_LAST) begin
               clk_cnt_d          = 16'd0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) state_d   = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

         S_STOP: begin
            if (clk_cnt_q == C_BIT_LAST) begin
               clk_cnt_d = 16'd0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end

         // A held-low line must return high before another frame can start.
         S_BREAK: begin
            clk_cnt_d = 16'd0;
            if (rx_s_q) state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = 16'd0;
         end
      endcase
   end

   assign data_out  = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : randomized self-checking bench for uart_rx against a
//              frame-level reference model.                        Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.CLK_PER_BIT(CPB)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data_out  (data_out),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation side: every rx_valid/frame_err event is logged at negedge.
   logic [7:0] vq[$];
   int         vt[$];
   logic       nbq[$];
   int         ferr_cnt  = 0;
   int         both_cnt  = 0;
   int         dbl_cnt   = 0;
   int         busy_cnt  = 0;
   logic       prev_v    = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_v)              nbq.push_back(busy);
         if (rx_valid) begin
            vq.push_back(data_out);
            vt.push_back(cyc);
         end
         if (frame_err)             ferr_cnt++;
         if (rx_valid && frame_err) both_cnt++;
         if (rx_valid && prev_v)    dbl_cnt++;
         if (busy)                  busy_cnt++;
      end
      prev_v = rx_valid;
   end

   // Reference model: a frame with a high stop bit delivers its byte,
   // a low stop bit yields one framing error and leaves data_out alone.
   logic [7:0] exp_q[$];
   logic [7:0] exp_data = 8'h00;
   int         exp_ferr = 0;
   int         rd       = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int p, input logic stop);
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      drive_bit(stop, p);
      if (stop) begin
         exp_q.push_back(d);
         exp_data = d;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic check_frames(input string tag);
      check({tag, " frame count"}, 32'(vq.size() - rd), 32'(exp_q.size()));
      foreach (exp_q[i])
         if (rd + i < vq.size()) check({tag, " byte"}, {24'd0, vq[rd+i]}, {24'd0, exp_q[i]});
      check({tag, " data_out held"}, {24'd0, data_out}, {24'd0, exp_data});
      check({tag, " frame_err count"}, 32'(ferr_cnt), 32'(exp_ferr));
      rd = vq.size();
      exp_q.delete();
   endtask

   initial begin
      int t0, lat, d, bc;
      int gap;
      logic [7:0] b;
      logic       st;

      rx    = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset data_out", {24'd0, data_out}, 32'h00);
      check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset frame_err", {31'd0, frame_err}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      drive_bit(1'b1, 5);

      // Short low pulse must be rejected as a false start.
      bc = busy_cnt;
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 30);
      check("glitch busy pulsed", {31'd0, (busy_cnt > bc)}, 32'd1);
      check("glitch busy idle", {31'd0, busy}, 32'd0);
      check_frames("glitch");

      // Single byte with latency and busy timing.
      t0 = cyc;
      send(8'hA5, CPB, 1'b1);
      drive_bit(1'b1, 6);
      if (rd < vq.size()) begin
         lat = vt[rd] - t0;
         check("A5 latency 154+-1", 32'((lat >= 153 && lat <= 155) ? 154 : lat), 32'd154);
      end
      if (rd < nbq.size()) check("A5 busy after valid", {31'd0, nbq[rd]}, 32'd0);
      check_frames("A5");

      // Framing error followed by a held-low line.
      send(8'h3C, CPB, 1'b0);
      drive_bit(1'b0, 64);
      check("break busy held", {31'd0, busy}, 32'd1);
      drive_bit(1'b1, 40);
      check("break busy released", {31'd0, busy}, 32'd0);
      check_frames("framing");

      // Back-to-back frames, no idle gap.
      send(8'h00, CPB, 1'b1);
      send(8'hFF, CPB, 1'b1);
      send(8'h55, CPB, 1'b1);
      drive_bit(1'b1, 20);
      if (vq.size() >= rd + 3) begin
         d = vt[rd+1] - vt[rd];
         check("b2b spacing 1", 32'((d >= 159 && d <= 161) ? 160 : d), 32'd160);
         d = vt[rd+2] - vt[rd+1];
         check("b2b spacing 2", 32'((d >= 159 && d <= 161) ? 160 : d), 32'd160);
      end
      check_frames("b2b");

      // Reset in the middle of bit 3 of 0x81, then an unrelated good frame.
      drive_bit(1'b0, CPB);
      drive_bit(1'b1, CPB);
      drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB / 2);
      reset = 1'b1;
      @(negedge clk);
      check("midreset data_out", {24'd0, data_out}, 32'h00);
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset pulses", {30'd0, rx_valid, frame_err}, 32'd0);
      reset    = 1'b0;
      exp_data = 8'h00;
      drive_bit(1'b1, 200);
      check_frames("after reset");
      send(8'h3C, CPB, 1'b1);
      drive_bit(1'b1, 20);
      check_frames("post-reset 3C");

      // Baud skew on both sides of nominal.
      send(8'hC3, CPB - 1, 1'b1);
      drive_bit(1'b1, 30);
      check_frames("skew 15");
      send(8'hC3, CPB + 1, 1'b1);
      drive_bit(1'b1, 30);
      check_frames("skew 17");

      // Random traffic with occasional bad stop bits.
      for (int i = 0; i < 24; i++) begin
         b   = 8'($urandom_range(0, 255));
         st  = ($urandom_range(0, 7) != 0);
         gap = $urandom_range(0, 12);
         if (!st && gap < 4) gap = 4;
         send(b, CPB, st);
         if (gap > 0) drive_bit(1'b1, gap);
      end
      drive_bit(1'b1, 40);
      check_frames("random");

      check("valid and frame_err together", 32'(both_cnt), 32'd0);
      check("rx_valid wider than one cycle", 32'(dbl_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
